// File: rtl/sync_timing_gen.sv
// sync_timing_gen
//   Generates one axis of a video-style timing period: SYNC, back porch,
//   ACTIVE and front porch phases. Each phase lasts its *_LEN enabled ticks.
//   The wrap strobe can drive the i_en of a second instance, so two
//   instances cascade into a horizontal/vertical pair.
//
//   Handshake: there is no valid/ready pair. i_en is a qualifier only.
//   State advances on a rising clk edge when i_en=1 and holds otherwise.
//   i_sclr wins over i_en on the same edge.
//
// Ports
//   clk      rising-edge clock
//   i_sclr   synchronous active-high clear (back to SYNC, position 0)
//   i_en     tick enable (upstream o_wrap when cascaded)
//   o_sync   SYNC_POL during SYNC, ~SYNC_POL otherwise
//   o_active 1 during ACTIVE only
//   o_idx    index inside ACTIVE; 0 outside ACTIVE
//   o_phase  0 SYNC, 1 BP, 2 ACTIVE, 3 FP (also the FSM state for debug)
//   o_pos    absolute position, 0..TOTAL-1
//   o_wrap   i_en & (o_pos == TOTAL-1), combinational
module sync_timing_gen #(
   parameter int SYNC_LEN   = 2,
   parameter int BP_LEN     = 33,
   parameter int ACTIVE_LEN = 480,
   parameter int FP_LEN     = 10,
   parameter bit SYNC_POL   = 1'b1,
   parameter int CNT_BIT    = 10,
   parameter int IDX_BIT    = 9
) (
   input  logic               clk,
   input  logic               i_sclr,
   input  logic               i_en,
   output logic               o_sync,
   output logic               o_active,
   output logic [IDX_BIT-1:0] o_idx,
   output logic [1:0]         o_phase,
   output logic [CNT_BIT-1:0] o_pos,
   output logic               o_wrap
);

   localparam int TOTAL = SYNC_LEN + BP_LEN + ACTIVE_LEN + FP_LEN;

   // Reject unsupported configurations at elaboration time.
   if (SYNC_LEN < 1 || BP_LEN < 1 || ACTIVE_LEN < 1 || FP_LEN < 1) begin : g_len_check
      $error("sync_timing_gen: every *_LEN must be at least 1");
   end
   if ((64'd1 << CNT_BIT) < 64'(TOTAL)) begin : g_cnt_check
      $error("sync_timing_gen: CNT_BIT too small for TOTAL");
   end
   if ((64'd1 << IDX_BIT) < 64'(ACTIVE_LEN)) begin : g_idx_check
      $error("sync_timing_gen: IDX_BIT too small for ACTIVE_LEN");
   end

   localparam logic [CNT_BIT-1:0] POS_LAST    = CNT_BIT'(TOTAL - 1);
   localparam logic [CNT_BIT-1:0] SYNC_LAST   = CNT_BIT'(SYNC_LEN - 1);
   localparam logic [CNT_BIT-1:0] BP_LAST     = CNT_BIT'(BP_LEN - 1);
   localparam logic [CNT_BIT-1:0] ACTIVE_LAST = CNT_BIT'(ACTIVE_LEN - 1);
   localparam logic [CNT_BIT-1:0] FP_LAST     = CNT_BIT'(FP_LEN - 1);

   typedef enum logic [1:0] {
      PH_SYNC   = 2'd0,
      PH_BP     = 2'd1,
      PH_ACTIVE = 2'd2,
      PH_FP     = 2'd3
   } phase_t;

   phase_t             phase, phase_nxt;
   logic [CNT_BIT-1:0] cnt, cnt_nxt;
   logic [CNT_BIT-1:0] pos, pos_nxt;
   logic [IDX_BIT-1:0] idx, idx_nxt;
   logic [CNT_BIT-1:0] phase_last;

   // State register
   always_ff @(posedge clk) begin
      if (i_sclr) begin
         phase <= PH_SYNC;
         cnt   <= '0;
         pos   <= '0;
         idx   <= '0;
      end else begin
         phase <= phase_nxt;
         cnt   <= cnt_nxt;
         pos   <= pos_nxt;
         idx   <= idx_nxt;
      end
   end

   // Terminal count of the in-phase counter for the current phase.
   always_comb begin
      phase_last = SYNC_LAST;
      case (phase)
         PH_SYNC:   phase_last = SYNC_LAST;
         PH_BP:     phase_last = BP_LAST;
         PH_ACTIVE: phase_last = ACTIVE_LAST;
         PH_FP:     phase_last = FP_LAST;
         default:   phase_last = SYNC_LAST;
      endcase
   end

   // Next-state logic
   always_comb begin
      phase_nxt = phase;
      cnt_nxt   = cnt;
      pos_nxt   = pos;
      idx_nxt   = idx;
      if (i_en) begin
         pos_nxt = (pos == POS_LAST) ? '0 : pos + 1'b1;
         if (cnt == phase_last) begin
            cnt_nxt = '0;
            case (phase)
               PH_SYNC:   phase_nxt = PH_BP;
               PH_BP:     phase_nxt = PH_ACTIVE;
               PH_ACTIVE: phase_nxt = PH_FP;
               PH_FP:     phase_nxt = PH_SYNC;
               default:   phase_nxt = PH_SYNC;
            endcase
         end else begin
            cnt_nxt = cnt + 1'b1;
         end
         // The index only counts while staying inside ACTIVE. Entering or
         // leaving ACTIVE loads 0, so it never leaks a stale value.
         idx_nxt = (phase == PH_ACTIVE && phase_nxt == PH_ACTIVE) ? idx + 1'b1 : '0;
      end
   end

   // Moore outputs
   assign o_phase  = phase;
   assign o_sync   = (phase == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
   assign o_active = (phase == PH_ACTIVE);
   assign o_idx    = idx;
   assign o_pos    = pos;

   // Combinational, so a cascaded instance steps on the same edge as this wrap.
   assign o_wrap   = i_en & (pos == POS_LAST);

endmodule

// File: tb/tb_sync_timing_gen.sv
module tb_sync_timing_gen;

   localparam int S = 2, B = 3, A = 4, F = 1, TOTAL = S + B + A + F;

   logic clk = 1'b0;
   logic i_sclr = 1'b0;
   logic i_en = 1'b0;

   logic       a_sync, a_active, a_wrap;
   logic [1:0] a_idx, a_phase;
   logic [3:0] a_pos;
   logic       b_sync, b_active, b_wrap;
   logic [1:0] b_idx, b_phase;
   logic [3:0] b_pos;
   logic       c_sync, c_active, c_wrap;
   logic [1:0] c_idx, c_phase;
   logic [3:0] c_pos;

   always #5 clk = ~clk;

   // Main instance, active-low sync
   sync_timing_gen #(.SYNC_LEN(S), .BP_LEN(B), .ACTIVE_LEN(A), .FP_LEN(F),
                     .SYNC_POL(1'b0), .CNT_BIT(4), .IDX_BIT(2)) dut_a (
      .clk(clk), .i_sclr(i_sclr), .i_en(i_en),
      .o_sync(a_sync), .o_active(a_active), .o_idx(a_idx),
      .o_phase(a_phase), .o_pos(a_pos), .o_wrap(a_wrap));

   // Cascaded instance driven by the main instance's wrap
   sync_timing_gen #(.SYNC_LEN(S), .BP_LEN(B), .ACTIVE_LEN(A), .FP_LEN(F),
                     .SYNC_POL(1'b0), .CNT_BIT(4), .IDX_BIT(2)) dut_b (
      .clk(clk), .i_sclr(i_sclr), .i_en(a_wrap),
      .o_sync(b_sync), .o_active(b_active), .o_idx(b_idx),
      .o_phase(b_phase), .o_pos(b_pos), .o_wrap(b_wrap));

   // Active-high sync instance running alongside the main one
   sync_timing_gen #(.SYNC_LEN(S), .BP_LEN(B), .ACTIVE_LEN(A), .FP_LEN(F),
                     .SYNC_POL(1'b1), .CNT_BIT(4), .IDX_BIT(2)) dut_c (
      .clk(clk), .i_sclr(i_sclr), .i_en(i_en),
      .o_sync(c_sync), .o_active(c_active), .o_idx(c_idx),
      .o_phase(c_phase), .o_pos(c_pos), .o_wrap(c_wrap));

   int n_checks = 0;
   int n_pass = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask

   // Reference model: just the absolute position of each instance.
   // Everything else is derived from the phase boundaries.
   int  m_pos = 0;
   int  m_pos_b = 0;
   bit  m_valid = 0;

   function automatic int ref_phase(input int p);
      if (p < S)             return 0;
      else if (p < S + B)    return 1;
      else if (p < S + B + A) return 2;
      else                   return 3;
   endfunction

   function automatic int ref_idx(input int p);
      return (ref_phase(p) == 2) ? p - (S + B) : 0;
   endfunction

   task automatic check_state();
      check("a_pos",    a_pos,    m_pos);
      check("a_phase",  a_phase,  ref_phase(m_pos));
      check("a_sync",   a_sync,   (ref_phase(m_pos) == 0) ? 0 : 1);
      check("a_active", a_active, (ref_phase(m_pos) == 2) ? 1 : 0);
      check("a_idx",    a_idx,    ref_idx(m_pos));
      check("b_pos",    b_pos,    m_pos_b);
      check("b_phase",  b_phase,  ref_phase(m_pos_b));
      check("c_pos",    c_pos,    m_pos);
      check("c_sync",   c_sync,   (ref_phase(m_pos) == 0) ? 1 : 0);
   endtask

   // One clock: drive inputs after the falling edge, check the combinational
   // wrap before the rising edge, then check registered state after it.
   task automatic step(input logic en, input logic sclr);
      @(negedge clk);
      i_en = en;
      i_sclr = sclr;
      #1;
      if (m_valid) begin
         check("a_wrap", a_wrap, (en && m_pos == TOTAL - 1) ? 1 : 0);
         check("b_wrap", b_wrap, (en && m_pos == TOTAL - 1 && m_pos_b == TOTAL - 1) ? 1 : 0);
      end
      @(posedge clk);
      if (sclr) begin
         m_pos = 0;
         m_pos_b = 0;
         m_valid = 1;
      end else if (en) begin
         if (m_pos == TOTAL - 1) m_pos_b = (m_pos_b + 1) % TOTAL;
         m_pos = (m_pos + 1) % TOTAL;
      end
      #1;
      if (m_valid) check_state();
   endtask

   initial begin
      // Clear with enable high: clear has priority
      step(1'b1, 1'b1);
      check("reset_pos", a_pos, 0);
      check("reset_sync_low", a_sync, 0);
      // With enable low after the clear, wrap stays low
      step(1'b0, 1'b0);
      check("reset_wrap", a_wrap, 0);

      // One full period of enabled ticks, back to 0
      for (int i = 0; i < TOTAL; i++) step(1'b1, 1'b0);
      check("period_back_to_0", a_pos, 0);
      check("cascade_one_step", b_pos, 1);

      // Alternating enable, across a wrap point
      for (int i = 0; i < 3 * TOTAL; i++) step(i[0] ? 1'b0 : 1'b1, 1'b0);

      // Move to position 7, then clear together with enable
      while (m_pos != 7) step(1'b1, 1'b0);
      check("pre_clear_idx", a_idx, 2);
      step(1'b1, 1'b1);
      check("mid_active_clear_pos", a_pos, 0);
      check("mid_active_clear_idx", a_idx, 0);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0);

      // Randomized stimulus with occasional clears
      for (int i = 0; i < 600; i++) begin
         step(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
              ($urandom_range(0, 63) == 0) ? 1'b1 : 1'b0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // Absolute time limit so the run always ends
   initial begin
      #200000;
      $display("FAIL timeout: got 0 expected 1");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/sync_timing_gen.md
SYNC_TIMING_GEN -- requirements
Module: sync_timing_gen

Interface
REQ-001 SHALL have parameter SYNC_LEN, default 2, sync pulse length in enabled ticks.
REQ-002 SHALL have parameter BP_LEN, default 33, back porch length in ticks.
REQ-003 SHALL have parameter ACTIVE_LEN, default 480, visible area length in ticks.
REQ-004 SHALL have parameter FP_LEN, default 10, front porch length in ticks.
REQ-005 SHALL have parameter SYNC_POL, default 1, level of o_sync during the sync phase (1 = active-high, 0 = active-low).
REQ-006 SHALL have parameter CNT_BIT, default 10, width of o_pos; must satisfy 2^CNT_BIT >= TOTAL, where TOTAL = SYNC_LEN+BP_LEN+ACTIVE_LEN+FP_LEN.
REQ-007 SHALL have parameter IDX_BIT, default 9, width of o_idx; must satisfy 2^IDX_BIT >= ACTIVE_LEN.
REQ-008 SHALL use one clock; reset is synchronous and active-high.
REQ-009 clk  input  1  rising-edge clock.
REQ-010 i_sclr  input  1  synchronous active-high clear.
REQ-011 i_en  input  1  tick enable; the timing advances only on clk edges where this is 1; driven by the upstream wrap output when cascaded.
REQ-012 o_sync  output  1  sync pulse; equals SYNC_POL in the SYNC phase, otherwise ~SYNC_POL.
REQ-013 o_active  output  1  1 in the ACTIVE phase only.
REQ-014 o_idx  output  IDX_BIT  index within the visible area.
REQ-015 o_phase  output  2  current phase: 0 SYNC, 1 BP, 2 ACTIVE, 3 FP.
REQ-016 o_pos  output  CNT_BIT  absolute position in the period, 0..TOTAL-1.
REQ-017 o_wrap  output  1  period-end strobe for cascading.

Function
REQ-018 Internal state SHALL be registered: phase register (four-state FSM), in-phase counter, o_pos counter and o_idx register.
REQ-019 o_sync, o_active, o_phase, o_pos and o_idx SHALL be Moore outputs decoded from registered state only.
REQ-020 On each clk edge with i_en=1, o_pos SHALL increment, wrapping from TOTAL-1 to 0.
REQ-021 With i_en=0, all state SHALL hold.
REQ-022 The FSM SHALL be SYNC -> BP -> ACTIVE -> FP -> SYNC; each phase spans exactly its *_LEN enabled ticks.
REQ-023 Each phase transition SHALL occur on the enabled edge on which the in-phase counter equals (*_LEN - 1); that edge clears the in-phase counter to 0.
REQ-024 o_phase SHALL equal 0 for o_pos in 0..SYNC_LEN-1, 1 for the following BP_LEN positions, 2 for the following ACTIVE_LEN positions, and 3 for the final FP_LEN positions.
REQ-025 o_idx SHALL be 0 on entry to ACTIVE and SHALL increment by 1 per enabled tick within ACTIVE, reaching ACTIVE_LEN-1 at the end of the phase.
REQ-026 o_idx SHALL read 0 whenever o_active=0; it SHALL never expose an underflowed value.
REQ-027 o_wrap SHALL be combinational and equal i_en AND (o_pos == TOTAL-1), so a downstream instance advances on the same edge this instance wraps.
REQ-028 A *_LEN of 1 SHALL yield a one-tick phase.
REQ-029 Any *_LEN of 0 is unsupported and SHALL be rejected at elaboration.
REQ-030 All arithmetic SHALL be unsigned, and counters SHALL not exceed their terminal values.

Reset
REQ-031 On a clk edge with i_sclr=1, the block SHALL load: phase SYNC, in-phase counter 0, o_pos 0, o_idx 0.
REQ-032 After that edge, outputs SHALL be: o_sync=SYNC_POL, o_active=0, o_phase=0, o_wrap=0 while i_en=0.
REQ-033 i_sclr SHALL take priority over i_en on the same edge.
REQ-034 i_sclr asserted mid-ACTIVE or mid-FP SHALL restart the period at position 0 on the next edge, with no partial wrap strobe generated afterwards.

Verification (SYNC_LEN=2, BP_LEN=3, ACTIVE_LEN=4, FP_LEN=1, SYNC_POL=0, TOTAL=10)
REQ-035 Reset with i_en=1 -> o_pos=0, o_phase=0, o_sync=0, o_active=0, o_idx=0 after the edge.
REQ-036 10 consecutive enabled ticks from reset -> o_phase sequence 0,0,1,1,1,2,2,2,2,3; o_idx=0,1,2,3 during positions 5..8; o_wrap=1 only at o_pos=9; then back to o_pos=0.
REQ-037 i_en toggled 1/0 alternately -> state advances only on enabled edges; o_wrap=0 on every edge with i_en=0 even at o_pos=9.
REQ-038 i_sclr=1 at o_pos=7 (o_idx=2) together with i_en=1 -> next o_pos=0, o_phase=0, o_idx=0; no o_wrap strobe.
REQ-039 Cascade: a second instance with i_en wired to the first instance's o_wrap -> the second instance's o_pos advances by exactly 1 per 10 enabled ticks of the first.
REQ-040 SYNC_POL=1 instance -> o_sync=1 at o_pos 0..1, 0 at o_pos 2..9.
